// File: rtl/branch_ex.sv
// Branch execute stage: resolves branches/jumps, issues a registered redirect and
// link write-back, squashes shadow instructions for a fixed window, counts branches.
module branch_ex #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             is_nop_in,
    input  logic             is_jmp_in,
    input  logic             is_imm_type_in,
    input  logic             zero_ext_in,
    input  logic [1:0]       op_in,
    input  logic [4:0]       rd_in,
    input  logic [19:0]      imm_in,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      rs1_data_in,
    input  logic [31:0]      rs2_data_in,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int unsigned SQ_W = 4;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [SQ_W-1:0]   sq_cnt, sq_cnt_nxt;
    logic              redirect_valid_nxt, wb_valid_nxt;
    logic [31:0]       redirect_pc_nxt, wb_data_nxt;
    logic [4:0]        wb_rd_nxt;
    logic [CNT_W-1:0]  branch_count_nxt, taken_count_nxt;

    logic        eval;
    logic        taken;
    logic        lt;
    logic [31:0] offset;
    logic [31:0] pc_rel;
    logic [31:0] target;

    // Datapath: target and condition evaluation.
    always_comb begin
        offset = {{10{imm_in[19]}}, imm_in, 2'b00};
        pc_rel = pc_in + offset;
        lt     = zero_ext_in ? (rs1_data_in < rs2_data_in)
                             : ($signed(rs1_data_in) < $signed(rs2_data_in));
        taken  = 1'b0;
        target = pc_rel;
        if (is_jmp_in) begin
            taken  = 1'b1;
            target = (is_imm_type_in ? pc_rel : rs1_data_in) & 32'hFFFF_FFFC;
        end else begin
            unique case (op_in)
                2'b00:   taken = (rs1_data_in == rs2_data_in);
                2'b01:   taken = (rs1_data_in != rs2_data_in);
                2'b10:   taken = lt;
                default: taken = ~lt;
            endcase
        end
        eval = ~stall && (state == IDLE) && ~is_nop_in;
    end

    // Next-state and registered-output logic; stall holds everything.
    always_comb begin
        state_nxt          = state;
        sq_cnt_nxt         = sq_cnt;
        redirect_valid_nxt = redirect_valid;
        redirect_pc_nxt    = redirect_pc;
        wb_valid_nxt       = wb_valid;
        wb_rd_nxt          = wb_rd;
        wb_data_nxt        = wb_data;
        branch_count_nxt   = branch_count;
        taken_count_nxt    = taken_count;
        if (!stall) begin
            redirect_valid_nxt = 1'b0;
            wb_valid_nxt       = 1'b0;
            unique case (state)
                IDLE: begin
                    if (eval) begin
                        branch_count_nxt = branch_count + CNT_W'(1);
                        if (taken) begin
                            taken_count_nxt    = taken_count + CNT_W'(1);
                            redirect_valid_nxt = 1'b1;
                            redirect_pc_nxt    = target;
                            state_nxt          = FLUSH;
                            sq_cnt_nxt         = SQ_W'(FLUSH_CYCLES);
                        end
                        if (is_jmp_in && (rd_in != 5'd0)) begin
                            wb_valid_nxt = 1'b1;
                            wb_rd_nxt    = rd_in;
                            wb_data_nxt  = pc_in + 32'd4;
                        end
                    end
                end
                default: begin
                    sq_cnt_nxt = sq_cnt - SQ_W'(1);
                    if (sq_cnt == SQ_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sq_cnt         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            branch_count   <= '0;
            taken_count    <= '0;
        end else begin
            state          <= state_nxt;
            sq_cnt         <= sq_cnt_nxt;
            redirect_valid <= redirect_valid_nxt;
            redirect_pc    <= redirect_pc_nxt;
            wb_valid       <= wb_valid_nxt;
            wb_rd          <= wb_rd_nxt;
            wb_data        <= wb_data_nxt;
            branch_count   <= branch_count_nxt;
            taken_count    <= taken_count_nxt;
        end
    end

    assign flush = (state == FLUSH);

endmodule

// File: tb/tb_branch_ex.sv
// Directed self-checking bench for branch_ex with hand-computed expectations.
module tb_branch_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        is_nop_in, is_jmp_in, is_imm_type_in, zero_ext_in;
    logic [1:0]  op_in;
    logic [4:0]  rd_in;
    logic [19:0] imm_in;
    logic [31:0] pc_in, rs1_data_in, rs2_data_in;
    logic        redirect_valid, flush, wb_valid;
    logic [31:0] redirect_pc, wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] branch_count, taken_count;

    int tests  = 0;
    int failed = 0;

    branch_ex #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .is_nop_in(is_nop_in), .is_jmp_in(is_jmp_in), .is_imm_type_in(is_imm_type_in),
        .zero_ext_in(zero_ext_in), .op_in(op_in), .rd_in(rd_in), .imm_in(imm_in),
        .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        is_nop_in = 1'b1; is_jmp_in = 1'b0; is_imm_type_in = 1'b0; zero_ext_in = 1'b0;
        op_in = 2'b00; rd_in = 5'd0; imm_in = 20'd0; pc_in = 32'd0;
        rs1_data_in = 32'd0; rs2_data_in = 32'd0;
    endtask

    task automatic set_br(input logic [1:0] op, input logic zx, input logic [31:0] pc,
                          input logic [19:0] imm, input logic [31:0] a, input logic [31:0] b);
        is_nop_in = 1'b0; is_jmp_in = 1'b0; is_imm_type_in = 1'b1; zero_ext_in = zx;
        op_in = op; rd_in = 5'd3; imm_in = imm; pc_in = pc;
        rs1_data_in = a; rs2_data_in = b;
    endtask

    task automatic set_jmp(input logic imm_type, input logic [4:0] rd, input logic [31:0] pc,
                           input logic [19:0] imm, input logic [31:0] a);
        is_nop_in = 1'b0; is_jmp_in = 1'b1; is_imm_type_in = imm_type; zero_ext_in = 1'b0;
        op_in = 2'b01; rd_in = rd; imm_in = imm; pc_in = pc;
        rs1_data_in = a; rs2_data_in = 32'd0;
    endtask

    initial begin
        // Reset with random, non-nop inputs.
        rst = 1'b1; stall = 1'b0;
        is_nop_in = 1'b0; is_jmp_in = 1'b1; is_imm_type_in = $urandom_range(0, 1);
        zero_ext_in = $urandom_range(0, 1); op_in = 2'($urandom_range(0, 3));
        rd_in = 5'd7; imm_in = 20'($urandom); pc_in = $urandom;
        rs1_data_in = $urandom; rs2_data_in = $urandom;
        #2;
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        tick();
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_taken_count", taken_count, 32'd0);

        rst = 1'b0;
        set_nop();
        for (int i = 0; i < 5; i++) tick();
        chk("nop_branch_count", branch_count, 32'd0);
        chk("nop_taken_count", taken_count, 32'd0);
        chk("nop_redirect_valid", 32'(redirect_valid), 32'd0);

        // BEQ taken: 0x100 + (4<<2) = 0x110.
        set_br(2'b00, 1'b0, 32'h100, 20'h00004, 32'd7, 32'd7);
        tick();
        set_nop();
        chk("beq_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h110);
        chk("beq_flush1", 32'(flush), 32'd1);
        chk("beq_taken_count", taken_count, 32'd1);
        chk("beq_branch_count", branch_count, 32'd1);
        tick();
        chk("beq_pulse_clear", 32'(redirect_valid), 32'd0);
        chk("beq_flush2", 32'(flush), 32'd1);
        chk("beq_pc_hold", redirect_pc, 32'h110);
        tick();
        chk("beq_flush_drop", 32'(flush), 32'd0);

        // BLT signed: -1 < 1 taken; 0x200 + 0x20 = 0x220.
        set_br(2'b10, 1'b0, 32'h200, 20'h00008, 32'hFFFF_FFFF, 32'd1);
        tick();
        set_nop();
        chk("blt_s_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("blt_s_redirect_pc", redirect_pc, 32'h220);
        chk("blt_s_taken_count", taken_count, 32'd2);
        tick(); tick();
        chk("blt_s_flush_drop", 32'(flush), 32'd0);
        // BLT unsigned: 0xFFFFFFFF < 1 false.
        set_br(2'b10, 1'b1, 32'h200, 20'h00008, 32'hFFFF_FFFF, 32'd1);
        tick();
        set_nop();
        chk("blt_u_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("blt_u_flush", 32'(flush), 32'd0);
        chk("blt_u_branch_count", branch_count, 32'd3);
        chk("blt_u_taken_count", taken_count, 32'd2);

        // JALR-style jump: target 0x2003 & ~3, link 0x44 to x5.
        set_jmp(1'b0, 5'd5, 32'h40, 20'h00000, 32'h2003);
        tick();
        set_nop();
        chk("jalr_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("jalr_redirect_pc", redirect_pc, 32'h2000);
        chk("jalr_wb_valid", 32'(wb_valid), 32'd1);
        chk("jalr_wb_rd", 32'(wb_rd), 32'd5);
        chk("jalr_wb_data", wb_data, 32'h44);
        tick();
        chk("jalr_wb_clear", 32'(wb_valid), 32'd0);
        tick();
        // PC-relative jump with rd=0: 0x80 + 4 = 0x84, no link.
        set_jmp(1'b1, 5'd0, 32'h80, 20'h00001, 32'h0);
        tick();
        set_nop();
        chk("jal_rd0_wb_valid", 32'(wb_valid), 32'd0);
        chk("jal_rd0_redirect_pc", redirect_pc, 32'h84);
        chk("jal_counts", branch_count, 32'd5);
        tick(); tick();

        // Taken BEQ, then a taken BNE in the shadow across a 2-cycle stall.
        set_br(2'b00, 1'b0, 32'h300, 20'h00000, 32'd0, 32'd0);
        tick();
        set_br(2'b01, 1'b0, 32'h400, 20'h00004, 32'd1, 32'd2);
        stall = 1'b1;
        chk("shadow_redirect_pc", redirect_pc, 32'h300);
        chk("shadow_taken_count", taken_count, 32'd5);
        tick();
        chk("stall1_redirect_hold", 32'(redirect_valid), 32'd1);
        chk("stall1_flush", 32'(flush), 32'd1);
        tick();
        chk("stall2_redirect_hold", 32'(redirect_valid), 32'd1);
        chk("stall2_branch_count", branch_count, 32'd6);
        stall = 1'b0;
        tick();
        chk("unstall_redirect_clear", 32'(redirect_valid), 32'd0);
        chk("unstall_flush", 32'(flush), 32'd1);
        set_nop();
        tick();
        chk("shadow_flush_drop", 32'(flush), 32'd0);
        chk("shadow_bne_squashed", branch_count, 32'd6);
        chk("shadow_taken_same", taken_count, 32'd5);

        // Negative offset wrap: 0 + sext(0x80000)<<2 = 0xFFE00000; then reset mid-window.
        set_br(2'b00, 1'b0, 32'h0, 20'h80000, 32'd9, 32'd9);
        tick();
        set_nop();
        chk("wrap_redirect_pc", redirect_pc, 32'hFFE0_0000);
        chk("wrap_flush", 32'(flush), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_flush", 32'(flush), 32'd0);
        chk("midrst_branch_count", branch_count, 32'd0);
        chk("midrst_taken_count", taken_count, 32'd0);
        chk("midrst_redirect_valid", 32'(redirect_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
